// File: rtl/mc_control_fsm.sv
// ============================================================================
// mc_control_fsm
// ----------------------------------------------------------------------------
// Multicycle control unit for the 8-bit MIPS processor. It runs the shared
// datapath one state per clock. From the current state it drives every mux
// select, the register-file, memory and PC/IR write enables, and the ALU
// operation class. The only inputs are the instruction opcode and, when
// configured, a memory-ready handshake.
//
// Build option:
//   MEM_WAIT_EN - when defined, FETCH, MEMRD and MEMWR stall while
//                 mem_ready=0. In FETCH, ir_write and pc_write are then
//                 qualified by mem_ready. When not defined, mem_ready is
//                 ignored and each memory state lasts exactly one cycle.
//
// Ports:
//   clk           in   system clock; all state changes on the rising edge
//   rst_n         in   synchronous, active-low reset
//   opcode[5:0]   in   instruction opcode, sampled in DECODE only
//   mem_ready     in   memory access complete (MEM_WAIT_EN builds only)
//   pc_write      out  unconditional PC write
//   pc_write_cond out  branch-qualified PC write
//   iord          out  address mux: 0=PC, 1=ALUOut
//   mem_read      out  memory read strobe
//   mem_write     out  memory write strobe
//   ir_write      out  instruction register load
//   mem_to_reg    out  register write-data mux: 0=ALUOut, 1=MDR
//   reg_dst       out  destination register mux: 0=rt, 1=rd
//   reg_write     out  register-file write
//   alu_src_a     out  ALU A mux: 0=PC, 1=A register
//   alu_src_b[1:0] out ALU B mux: 00=B, 01=1, 10=sign-ext imm, 11=branch offs
//   alu_op[1:0]   out  00=add, 01=subtract, 10=funct-decoded
//   pc_source[1:0] out PC mux: 00=ALU result, 01=ALUOut, 10=jump target
//   instr_done    out  one-cycle pulse in an instruction's final state
//   illegal_op    out  one-cycle pulse after DECODE rejects an opcode
//   state[3:0]    out  current state encoding, for debug
// ============================================================================
module mc_control_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_ADDIEX = 4'd11,
        S_ADDIWB = 4'd12
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] opcode_q;
    logic       illegal_q, illegal_d;

    // mem_go is high when a memory state may complete this cycle.
    logic mem_go;
`ifdef MEM_WAIT_EN
    assign mem_go = mem_ready;
`else
    assign mem_go = 1'b1;
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
`endif

    // ------------------------------------------------------------------
    // State, latched opcode and illegal-op flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_RESET;
            opcode_q  <= 6'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            // Latch the opcode once so MEMADR is immune to later IR changes.
            if (state_q == S_DECODE) begin
                opcode_q <= opcode;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        case (state_q)
            S_RESET:  state_d = S_FETCH;
            S_FETCH:  if (mem_go) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW,
                    OP_SW:    state_d = S_MEMADR;
                    OP_RTYPE: state_d = S_EXEC;
                    OP_BEQ:   state_d = S_BRANCH;
                    OP_J:     state_d = S_JUMP;
                    OP_ADDI:  state_d = S_ADDIEX;
                    default: begin
                        // Illegal_op is registered so that it has no
                        // combinational path from opcode. The pulse
                        // therefore appears in the first cycle of the
                        // following FETCH.
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = (opcode_q == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_go) state_d = S_MEMWB;
            S_MEMWR:  if (mem_go) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_MEMWB,
            S_ALUWB,
            S_BRANCH,
            S_JUMP,
            S_ADDIWB: state_d = S_FETCH;
            // Unused encodings 13-15 recover to FETCH.
            default:  state_d = S_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // Moore output decode
    // ------------------------------------------------------------------
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        instr_done    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                // Load IR and increment PC once only, when the fetch completes.
                ir_write  = mem_go;
                pc_write  = mem_go;
                alu_src_b = 2'b01;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MEMADR,
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                mem_write  = 1'b1;
                iord       = 1'b1;
                // Pulse only on the completing cycle of a stalled store.
                instr_done = mem_go;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                instr_done    = 1'b1;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                instr_done = 1'b1;
            end
            S_ADDIWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign illegal_op = illegal_q;
    assign state      = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
module tb_mc_control_fsm;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       instr_done, illegal_op;
    logic [3:0] state;

    int passed = 0;
    int total  = 0;
    logic monitor_on = 1'b0;

    mc_control_fsm dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .instr_done    (instr_done),
        .illegal_op    (illegal_op),
        .state         (state)
    );

    always #5 clk = ~clk;

    // Bit order: 17 pc_write, 16 pc_write_cond, 15 iord, 14 mem_read,
    // 13 mem_write, 12 ir_write, 11 mem_to_reg, 10 reg_dst, 9 reg_write,
    // 8 alu_src_a, 7:6 alu_src_b, 5:4 alu_op, 3:2 pc_source,
    // 1 instr_done, 0 illegal_op
    logic [17:0] outs;
    assign outs = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
                   alu_op, pc_source, instr_done, illegal_op};

    // Hand-written output table per state (illegal_op is excluded).
    function automatic logic [17:0] exp_outs(input logic [3:0] s);
        logic [17:0] e;
        e = '0;
        case (s)
            4'd1:  begin e[17] = 1'b1; e[14] = 1'b1; e[12] = 1'b1; e[7:6] = 2'b01; end
            4'd2:  e[7:6] = 2'b11;
            4'd3,
            4'd11: begin e[8] = 1'b1; e[7:6] = 2'b10; end
            4'd4:  begin e[14] = 1'b1; e[15] = 1'b1; end
            4'd5:  begin e[9] = 1'b1; e[11] = 1'b1; e[1] = 1'b1; end
            4'd6:  begin e[13] = 1'b1; e[15] = 1'b1; e[1] = 1'b1; end
            4'd7:  begin e[8] = 1'b1; e[5:4] = 2'b10; end
            4'd8:  begin e[9] = 1'b1; e[10] = 1'b1; e[1] = 1'b1; end
            4'd9:  begin e[8] = 1'b1; e[5:4] = 2'b01; e[16] = 1'b1; e[3:2] = 2'b01; e[1] = 1'b1; end
            4'd10: begin e[17] = 1'b1; e[3:2] = 2'b10; e[1] = 1'b1; end
            4'd12: begin e[9] = 1'b1; e[1] = 1'b1; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mem_write and reg_write must never be asserted in the same cycle.
    always @(negedge clk) begin
        if (monitor_on) begin
            total++;
            if (mem_write && reg_write)
                $display("FAIL write_exclusive t=%0t got mem_write=1 reg_write=1 want not both", $time);
            else
                passed++;
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; opcode = OP_RTYPE; mem_ready = 1'b1;
        step(); step();
        total++;
        if (state !== 4'd0 || outs !== 18'd0)
            $display("FAIL reset_init got state=%0d outs=%h want state=0 outs=0", state, outs);
        else passed++;
        rst_n = 1'b1;
        step(); step(); step();
        total++;
        if (state !== 4'd7)
            $display("FAIL reset_reach_exec got state=%0d want 7", state);
        else passed++;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (state !== 4'd0 || outs !== 18'd0)
                $display("FAIL reset_mid_exec[%0d] got state=%0d outs=%h want state=0 outs=0", i, state, outs);
            else passed++;
        end
        rst_n = 1'b1;
        step();
        total++;
        if (state !== 4'd1 || outs !== exp_outs(4'd1) || !(mem_read && ir_write && pc_write))
            $display("FAIL reset_release got state=%0d outs=%h want state=1 outs=%h", state, outs, exp_outs(4'd1));
        else passed++;
    endtask

    task automatic test_lw();
        logic [3:0] seq [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
        int done_cnt = 0;
        opcode = OP_LW;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (state !== seq[i] || outs !== exp_outs(seq[i]))
                $display("FAIL lw[%0d] got state=%0d outs=%h want state=%0d outs=%h", i, state, outs, seq[i], exp_outs(seq[i]));
            else passed++;
            if (instr_done) done_cnt++;
            // Opcode is latched in DECODE; changing it now must not divert MEMADR.
            if (i == 2) opcode = OP_SW;
            step();
        end
        total++;
        if (state !== 4'd1)
            $display("FAIL lw_return got state=%0d want 1", state);
        else passed++;
        total++;
        if (done_cnt != 1)
            $display("FAIL lw_done_count got %0d want 1", done_cnt);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [3:0] seq [8] = '{4'd1, 4'd2, 4'd3, 4'd6, 4'd1, 4'd2, 4'd7, 4'd8};
        int done_cnt = 0;
        opcode = OP_SW;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (state !== seq[i] || outs !== exp_outs(seq[i]))
                $display("FAIL sw_rtype[%0d] got state=%0d outs=%h want state=%0d outs=%h", i, state, outs, seq[i], exp_outs(seq[i]));
            else passed++;
            if (instr_done) done_cnt++;
            if (i == 3) opcode = OP_RTYPE;
            step();
        end
        total++;
        if (state !== 4'd1 || done_cnt != 2)
            $display("FAIL sw_rtype_end got state=%0d done=%0d want state=1 done=2", state, done_cnt);
        else passed++;
    endtask

    task automatic test_beq_j();
        logic [3:0] seq [6] = '{4'd1, 4'd2, 4'd9, 4'd1, 4'd2, 4'd10};
        int done_cnt = 0;
        opcode = OP_BEQ;
        for (int i = 0; i < 6; i++) begin
            total++;
            if (state !== seq[i] || outs !== exp_outs(seq[i]))
                $display("FAIL beq_j[%0d] got state=%0d outs=%h want state=%0d outs=%h", i, state, outs, seq[i], exp_outs(seq[i]));
            else passed++;
            if (instr_done) done_cnt++;
            if (i == 2) opcode = OP_J;
            step();
        end
        total++;
        if (state !== 4'd1 || done_cnt != 2)
            $display("FAIL beq_j_end got state=%0d done=%0d want state=1 done=2", state, done_cnt);
        else passed++;
    endtask

    task automatic test_illegal();
        logic [3:0] seq [2] = '{4'd1, 4'd2};
        opcode = 6'b111111;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (state !== seq[i] || outs !== exp_outs(seq[i]))
                $display("FAIL illegal[%0d] got state=%0d outs=%h want state=%0d outs=%h", i, state, outs, seq[i], exp_outs(seq[i]));
            else passed++;
            step();
        end
        total++;
        if (state !== 4'd1 || outs !== (exp_outs(4'd1) | 18'h1))
            $display("FAIL illegal_pulse got state=%0d outs=%h want state=1 outs=%h", state, outs, exp_outs(4'd1) | 18'h1);
        else passed++;
        // Follow with ADDI: checks the pulse is a single cycle and covers ADDI.
        opcode = OP_ADDI;
        step();
        total++;
        if (state !== 4'd2 || outs !== exp_outs(4'd2))
            $display("FAIL illegal_clear got state=%0d outs=%h want state=2 outs=%h", state, outs, exp_outs(4'd2));
        else passed++;
        step();
        total++;
        if (state !== 4'd11 || outs !== exp_outs(4'd11))
            $display("FAIL addi_ex got state=%0d outs=%h want state=11 outs=%h", state, outs, exp_outs(4'd11));
        else passed++;
        step();
        total++;
        if (state !== 4'd12 || outs !== exp_outs(4'd12))
            $display("FAIL addi_wb got state=%0d outs=%h want state=12 outs=%h", state, outs, exp_outs(4'd12));
        else passed++;
        step();
        total++;
        if (state !== 4'd1)
            $display("FAIL addi_return got state=%0d want 1", state);
        else passed++;
    endtask

`ifdef MEM_WAIT_EN
    task automatic test_mem_wait();
        logic [3:0] seq [10] = '{4'd1, 4'd1, 4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd4, 4'd4, 4'd5};
        logic       rdy [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int irw = 0;
        int pcw = 0;
        logic [17:0] e;
        opcode = OP_LW;
        for (int i = 0; i < 10; i++) begin
            mem_ready = rdy[i];
            #1;
            e = exp_outs(seq[i]);
            if (seq[i] == 4'd1 && !rdy[i]) begin
                e[17] = 1'b0;
                e[12] = 1'b0;
            end
            total++;
            if (state !== seq[i] || outs !== e)
                $display("FAIL mem_wait[%0d] got state=%0d outs=%h want state=%0d outs=%h", i, state, outs, seq[i], e);
            else passed++;
            if (ir_write) irw++;
            if (pc_write) pcw++;
            step();
        end
        mem_ready = 1'b1;
        #1;
        total++;
        if (state !== 4'd1 || irw != 1 || pcw != 1)
            $display("FAIL mem_wait_end got state=%0d ir_write_cycles=%0d pc_write_cycles=%0d want 1/1/1", state, irw, pcw);
        else passed++;
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog timeout got running want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        monitor_on = 1'b1;
        test_lw();
        test_back_to_back();
        test_beq_j();
        test_illegal();
`ifdef MEM_WAIT_EN
        test_mem_wait();
`endif
        monitor_on = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
